seq_wide_adder_ctrl: RTL and testbench



---
 rtl/seq_wide_adder_ctrl.sv | 129 ++++++++++++
 tb/tb_seq_wide_adder_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_wide_adder_ctrl.sv
// Sequential wide adder: one N-bit ripple chunk adder reused over K cycles, LSB chunk first.
// Optional subtract mode (extra 'sub' port) is enabled by defining SEQ_WIDE_ADDER_SUB_EN.

module rippleChunkAdder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < N; i++) begin : gFullAdder
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[N];
endmodule

module seq_wide_adder_ctrl #(
  parameter int N = 4,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*K-1:0] inA,
  input  logic [N*K-1:0] inB,
  input  logic           cin,
`ifdef SEQ_WIDE_ADDER_SUB_EN
  input  logic           sub,
`endif
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           carry
);
  localparam int W  = N * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT         state;
  logic [W-1:0]  aReg;
  logic [W-1:0]  bReg;
  logic          cReg;
  logic [IW-1:0] idx;

  logic [W-1:0]  bCapture;
  logic          cCapture;
  logic [N-1:0]  aChunk;
  logic [N-1:0]  bChunk;
  logic [N-1:0]  chunkSum;
  logic          chunkCout;

  // Subtraction is A + ~B + 1, so operand conditioning happens once at capture.
  always_comb begin
    bCapture = inB;
    cCapture = cin;
`ifdef SEQ_WIDE_ADDER_SUB_EN
    if (sub) begin
      bCapture = ~inB;
      cCapture = 1'b1;
    end
`endif
    aChunk = aReg[idx*N +: N];
    bChunk = bReg[idx*N +: N];
  end

  rippleChunkAdder #(.N(N)) uChunkAdder (
    .a  (aChunk),
    .b  (bChunk),
    .ci (cReg),
    .s  (chunkSum),
    .co (chunkCout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are plain flops, not a memory, so they reset with everything else.
    if (!rst_n) begin
      state <= IDLE;
      aReg  <= '0;
      bReg  <= '0;
      cReg  <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every branch read pre-edge idx/cReg consistently.
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            aReg  <= inA;
            bReg  <= bCapture;
            cReg  <= cCapture;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*N +: N] <= chunkSum;
          cReg            <= chunkCout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            carry <= chunkCout;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Scoreboard bench for seq_wide_adder_ctrl: model pushes expected results on acceptance, monitor pops on done.
// Compile with SEQ_WIDE_ADDER_SUB_EN defined to also exercise subtract mode.

module tb_seq_wide_adder_ctrl;
  localparam int N = 4;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] inA = '0;
  logic [W-1:0] inB = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;

  seq_wide_adder_ctrl #(.N(N), .K(K)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .inA   (inA),
    .inB   (inB),
    .cin   (cin),
`ifdef SEQ_WIDE_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned sumV;
    bit              carryV;
    int              doneCyc;
  } expT;

  expT sbq[$];
  int  cyc = 0;
  int  nextFree = 0;
  int  lastAccept = -1;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned arithmetic modulo 2^W, carry is bit W (no-borrow flag when subtracting).
  function automatic expT refModel(input longint unsigned a, input longint unsigned b,
                                   input bit c, input bit s, input int dc);
    expT             e;
    longint unsigned m = 64'd1 << W;
    longint unsigned r;
    if (s) begin
      e.sumV   = (a + m - b) % m;
      e.carryV = (a >= b);
    end else begin
      r        = a + b + c;
      e.sumV   = r % m;
      e.carryV = (r >= m);
    end
    e.doneCyc = dc;
    return e;
  endfunction

  // Acceptance model: an op is taken on any edge with start high once K+2 cycles have passed.
  always @(posedge clk) begin
    bit subNow;
`ifdef SEQ_WIDE_ADDER_SUB_EN
    subNow = sub;
`else
    subNow = 1'b0;
`endif
    if (rst_n && start && cyc >= nextFree) begin
      sbq.push_back(refModel(inA, inB, cin, subNow, cyc + K + 1));
      lastAccept = cyc;
      nextFree   = cyc + K + 2;
    end
    cyc++;
  end

  // Monitor: samples on the falling edge, checks busy every cycle and results on done.
  always @(negedge clk) begin
    expT e;
    bit  expBusy;
    if (rst_n) begin
      expBusy = (lastAccept >= 0) && (cyc >= lastAccept + 1) && (cyc <= lastAccept + K + 1);
      check("busy", busy, expBusy);
      if (done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", done, 1'b0);
        end else begin
          e = sbq.pop_front();
          check("sum", sum, e.sumV);
          check("carry", carry, e.carryV);
          check("done_cycle", cyc, e.doneCyc);
        end
      end else if (sbq.size() > 0 && sbq[0].doneCyc <= cyc) begin
        check("done_missing", done, 1'b1);
        void'(sbq.pop_front());
      end
    end
  end

  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input bit c, input bit s,
                       input logic [W-1:0] expSum, input bit expCarry, input string name);
    bit seen = 0;
    @(negedge clk);
    inA = a; inB = b; cin = c; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1'b1);
    check({name, "_sum"}, sum, expSum);
    check({name, "_carry"}, carry, expCarry);
    sub = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    runOp(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, "basic");
    runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "ripple");
    runOp(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, "cin");
`ifdef SEQ_WIDE_ADDER_SUB_EN
    runOp(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
    runOp(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
`endif

    // start held high with operands changing every cycle
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      inA = W'($urandom);
      inB = W'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (K + 3) @(negedge clk);

    // reset during the third RUN cycle aborts with no done
    inA = 16'hABCD; inB = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 0);
    check("abort_carry", carry, 1'b0);
    sbq.delete();
    lastAccept = -1;
    nextFree   = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (K + 2) @(negedge clk);
    runOp(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, "post_abort");

    // random start pulses and operands
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) < 3);
      inA   = W'($urandom);
      inB   = W'($urandom);
      cin   = 1'($urandom);
`ifdef SEQ_WIDE_ADDER_SUB_EN
      sub   = 1'($urandom);
`endif
    end
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(negedge clk);
    check("drain", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
